pixel_threshold_pipe: RTL and testbench
=======================================

Name: pixel_threshold_pipe

Overview:
- Parametrised, pipelined successor to the camera-path colour filter.
- Converts streamed RGB pixels to YCbCr (BT.601 integer), applies a window threshold and outputs bypass, binary mask, masked colour or grayscale.
- Valid/ready handshake with back-pressure; thresholds are frame-synchronous; per-frame matched-pixel count.
- Sits between the camera pixel stream and the VGA frame buffer writer; thresholds and mode come from switches.

Parameters:
- COLOR_W, 4, bits per colour channel (legal 4..8); pixel bus is 3*COLOR_W, ordered {R,G,B}.
- CNT_W, 19, width of the matched-pixel counter (640x480 fits).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_pixel  in  3*COLOR_W  RGB pixel
- in_sof  in  1  first pixel of frame (qualified by in_valid)
- in_eof  in  1  last pixel of frame
- mode  in  2  00 bypass, 01 binary mask, 10 masked colour, 11 grayscale
- y_min, cb_min, cb_max, cr_min, cr_max  in  8 each  threshold window
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_pixel  out  3*COLOR_W  processed pixel
- out_sof, out_eof  out  1 each  frame markers delayed with their pixel
- out_match  out  1  pixel fell inside the window
- match_count  out  CNT_W  matched pixels in last completed frame
- count_valid  out  1  one-cycle pulse when match_count updates

Behaviour:
- Clock and reset: one clock; reset is synchronous, active-low.
- Reset values:
  - All stage valids, out_valid, count_valid, out_sof, out_eof and out_match are 0.
  - out_pixel and match_count are 0; the running counter is 0.
  - Shadow mode is 00; shadow thresholds are y_min=0, cb 0..255, cr 0..255 (match all).
- Pipeline: 4 registered stages, each with a valid bit.
  - S1: expand each channel to 8 bits by MSB replication (4-bit 0x8 -> 0x88); capture the shadow config.
  - S2: the nine signed products.
  - S3: sums, then arithmetic shift right 8 (floor):
    - Y = (77R + 150G + 29B) >> 8
    - Cb = ((-43R - 85G + 128B) >> 8) + 128
    - Cr = ((128R - 107G - 21B) >> 8) + 128
    - Clamp each result to 0..255.
  - S4: match = (Y >= y_min) && cb_min <= Cb <= cb_max && cr_min <= Cr <= cr_max (all inclusive); select output.
- Output select:
  - 00: original pixel.
  - 01: all-ones if match, else 0.
  - 10: original pixel if match, else 0.
  - 11: Y[7:8-COLOR_W] replicated to R, G and B.
  - match and counting are computed in every mode.
- Latency: 4 cycles from an accepted input to out_valid, with no stalls.
- Handshake:
  - en = !out_valid || out_ready; in_ready = en (combinational from out_ready).
  - When en=0 every stage holds, including data, valid bits and markers.
  - Bubbles propagate as valid=0.
  - out_pixel, out_sof, out_eof and out_match stay stable while out_valid && !out_ready.
- Frame config:
  - mode and thresholds are latched into shadow registers when a pixel with in_sof is accepted.
  - That pixel and all later ones use the new config.
  - Changes mid-frame have no effect; the config travels with the pixel through the pipeline.
- Counter:
  - Updates on an output transfer (out_valid && out_ready).
  - If out_sof, the counter loads match?1:0; otherwise it adds match.
  - Saturates at 2^CNT_W-1.
  - The cycle after an out_eof transfer, match_count takes the final count and count_valid pulses for 1 cycle.
  - A single-pixel frame (sof and eof set together) gives a count of match?1:0.
  - An eof without a preceding sof still reports the running count.
- Reset mid-frame: pipeline contents are discarded, no count_valid is produced, and the shadow config returns to its reset value.

Test Plan:
- Reset, then stream a frame with sof on 0xF00, pixels 0xF00, 0x0F0, 0x00F, 0x888, 0xFF0, eof on the last. Config: mode=01, y_min=32, cb 0..120, cr 160..255, out_ready=1.
  - Required out_pixel: FFF, 000, 000, 000, 000, each 4 cycles after input.
  - Internal (Y,Cb,Cr): red (76,85,255), green (149,43,21), blue (28,255,107), gray (136,128,128), yellow (226,0,148).
  - match_count=1 with a count_valid pulse.
- Same frame with mode=10 -> F00, 000, 000, 000, 000. With mode=11, gray 0x888 -> 0x888 and red -> 0x444.
- Hold out_ready=0 for 5 cycles mid-stream -> in_ready drops, out_pixel stays stable, no pixel is lost or duplicated, order is preserved.
- Change cr_min to 0 mid-frame -> the current frame is unaffected; the next frame with sof counts green and gray as matching if they fall within the other limits.
- Frame of 8 red pixels with COLOR_W=8 (0xFF0000) and a 1-pixel frame -> counts 8 and 1; CNT_W=3 with 9 reds saturates at 7.
- Assert reset_n=0 for 1 cycle with 3 pixels in flight -> out_valid=0 the next cycle, no count_valid, and the shadow config is back to match-all.

Source files
------------

// File: rtl/pixel_threshold_pipe.sv
// pixel_threshold_pipe: RGB->YCbCr window threshold filter with frame-synchronous config and match counting
module pixel_threshold_pipe #(
   parameter int COLOR_W = 4,
   parameter int CNT_W = 19
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3*COLOR_W-1:0] in_pixel,
   input  logic                 in_sof,
   input  logic                 in_eof,
   input  logic [1:0]           mode,
   input  logic [7:0]           y_min,
   input  logic [7:0]           cb_min,
   input  logic [7:0]           cb_max,
   input  logic [7:0]           cr_min,
   input  logic [7:0]           cr_max,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3*COLOR_W-1:0] out_pixel,
   output logic                 out_sof,
   output logic                 out_eof,
   output logic                 out_match,
   output logic [CNT_W-1:0]     match_count,
   output logic                 count_valid
);
   localparam int PW = 3*COLOR_W;
   typedef struct packed {
      logic [1:0] mode;
      logic [7:0] y_min, cb_min, cb_max, cr_min, cr_max;
   } cfg_t;
   typedef struct packed {
      logic [PW-1:0] px;
      logic          sof, eof;
      cfg_t          cfg;
   } side_t;
   localparam cfg_t CFG_RST = '{mode: 2'b00, y_min: 8'd0, cb_min: 8'd0, cb_max: 8'hff, cr_min: 8'd0, cr_max: 8'hff};
   // rows: Y, Cb, Cr; columns: R, G, B
   localparam logic signed [17:0] K [9] = '{18'sd77, 18'sd150, 18'sd29, -18'sd43, -18'sd85, 18'sd128, 18'sd128, -18'sd107, -18'sd21};

   function automatic logic [7:0] exp8(input logic [COLOR_W-1:0] c);
      logic [2*COLOR_W-1:0] d;
      d = {c, c};
      return d[2*COLOR_W-1 -: 8];
   endfunction

   function automatic logic [7:0] clamp8(input logic signed [17:0] v);
      return v[17] ? 8'd0 : v > 18'sd255 ? 8'hff : v[7:0];
   endfunction

   cfg_t               sh_cfg, live_cfg;
   side_t              s1, s2, s3;
   logic [3:1]         v;
   logic [7:0]         ch8 [3];
   logic signed [17:0] prod [9];
   logic signed [17:0] sum [3];
   logic [7:0]         ycc [3];
   logic               en, xfer, m;
   logic [PW-1:0]      sel;
   logic [CNT_W-1:0]   cnt, cnt_nx;

   assign en = !out_valid || out_ready;
   assign in_ready = en;
   assign xfer = out_valid && out_ready;
   assign live_cfg = {mode, y_min, cb_min, cb_max, cr_min, cr_max};

   always_comb begin
      for (int j = 0; j < 3; j++)
         sum[j] = ((prod[3*j] + prod[3*j+1] + prod[3*j+2]) >>> 8) + (j == 0 ? 18'sd0 : 18'sd128);
      m = ycc[0] >= s3.cfg.y_min && ycc[1] >= s3.cfg.cb_min && ycc[1] <= s3.cfg.cb_max &&
          ycc[2] >= s3.cfg.cr_min && ycc[2] <= s3.cfg.cr_max;
      sel = s3.cfg.mode == 2'd0 ? s3.px :
            s3.cfg.mode == 2'd1 ? {PW{m}} :
            s3.cfg.mode == 2'd2 ? (m ? s3.px : '0) : {3{ycc[0][7 -: COLOR_W]}};
      cnt_nx = out_sof ? CNT_W'(out_match) : cnt + CNT_W'(out_match & ~&cnt);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         v <= '0;
         out_valid <= 1'b0;
         out_sof <= 1'b0;
         out_eof <= 1'b0;
         out_match <= 1'b0;
         out_pixel <= '0;
         count_valid <= 1'b0;
         match_count <= '0;
         cnt <= '0;
         sh_cfg <= CFG_RST;
      end else begin
         count_valid <= xfer && out_eof;
         if (xfer) cnt <= cnt_nx;
         if (xfer && out_eof) match_count <= cnt_nx;
         if (en) begin
            if (in_valid && in_sof) sh_cfg <= live_cfg;
            v <= {v[2:1], in_valid};
            out_valid <= v[3];
            s1 <= '{px: in_pixel, sof: in_valid & in_sof, eof: in_valid & in_eof, cfg: in_sof ? live_cfg : sh_cfg};
            for (int i = 0; i < 3; i++) ch8[i] <= exp8(in_pixel[PW-1-COLOR_W*i -: COLOR_W]);
            s2 <= s1;
            for (int i = 0; i < 9; i++) prod[i] <= K[i] * $signed({10'd0, ch8[i % 3]});
            s3 <= s2;
            for (int i = 0; i < 3; i++) ycc[i] <= clamp8(sum[i]);
            out_pixel <= sel;
            out_sof <= s3.sof;
            out_eof <= s3.eof;
            out_match <= m;
         end
      end
   end
endmodule

// File: tb/tb_pixel_threshold_pipe.sv
// tb_pixel_threshold_pipe: self-checking bench with a frame-level behavioural model of the threshold pipe
module tb_pixel_threshold_pipe;
   localparam int CW = 4;
   localparam int PW = 12;
   localparam int CMAX = (1 << 19) - 1;
   typedef struct {
      logic [PW-1:0] px;
      logic          sof, eof, m;
      int            cyc;
   } exp_t;

   logic clk = 0;
   always #5 clk = ~clk;

   logic          reset_n = 0, in_valid = 0, in_sof = 0, in_eof = 0, out_ready = 1;
   logic [PW-1:0] in_pixel = '0;
   logic [1:0]    mode = 2'b01;
   logic [7:0]    y_min = 8'd32, cb_min = 8'd0, cb_max = 8'd120, cr_min = 8'd160, cr_max = 8'd255;
   logic          in_ready, out_valid, out_sof, out_eof, out_match, count_valid;
   logic [PW-1:0] out_pixel;
   logic [18:0]   match_count;

   logic          in_valid8 = 0, in_sof8 = 0, in_eof8 = 0;
   logic          in_ready8, out_valid8, out_sof8, out_eof8, out_match8, count_valid8;
   logic [23:0]   out_pixel8;
   logic [2:0]    match_count8;

   pixel_threshold_pipe #(.COLOR_W(4), .CNT_W(19)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
      .in_sof(in_sof), .in_eof(in_eof), .mode(mode), .y_min(y_min), .cb_min(cb_min), .cb_max(cb_max),
      .cr_min(cr_min), .cr_max(cr_max), .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
      .out_sof(out_sof), .out_eof(out_eof), .out_match(out_match), .match_count(match_count),
      .count_valid(count_valid));

   pixel_threshold_pipe #(.COLOR_W(8), .CNT_W(3)) dut8 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8), .in_pixel(24'hFF0000),
      .in_sof(in_sof8), .in_eof(in_eof8), .mode(2'b10), .y_min(8'd0), .cb_min(8'd0), .cb_max(8'd255),
      .cr_min(8'd0), .cr_max(8'd255), .out_valid(out_valid8), .out_ready(1'b1), .out_pixel(out_pixel8),
      .out_sof(out_sof8), .out_eof(out_eof8), .out_match(out_match8), .match_count(match_count8),
      .count_valid(count_valid8));

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // model state: shadow config, expected outputs, frame counter
   logic [1:0]    sm;
   int            sy, scbn, scbx, scrn, scrx;
   exp_t          q[$];
   exp_t          e;
   int            cyc = 0, cnt = 0, exp_cnt = 0;
   bit            exp_cv = 0, hold_v = 0;
   logic [PW+2:0] hold;
   logic [PW-1:0] log_px [64];
   int            log_lat [64];
   int            nlog = 0;
   int            cnt_log [16];
   int            ncnt = 0;

   function automatic int clampi(input int x);
      return x < 0 ? 0 : x > 255 ? 255 : x;
   endfunction

   function automatic exp_t model(input logic [PW-1:0] px, input logic s, input logic eo);
      int c [3];
      int y, cb, cr, g;
      exp_t r;
      for (int i = 0; i < 3; i++) c[i] = ((px >> ((2 - i) * CW)) & 15) * 17;
      y  = clampi((77*c[0] + 150*c[1] + 29*c[2]) >>> 8);
      cb = clampi(((-43*c[0] - 85*c[1] + 128*c[2]) >>> 8) + 128);
      cr = clampi(((128*c[0] - 107*c[1] - 21*c[2]) >>> 8) + 128);
      r.m = y >= sy && cb >= scbn && cb <= scbx && cr >= scrn && cr <= scrx;
      g = y >> 4;
      case (sm)
         2'd0: r.px = px;
         2'd1: r.px = r.m ? 12'hFFF : 12'h000;
         2'd2: r.px = r.m ? px : 12'h000;
         default: r.px = PW'(g * 12'h111);
      endcase
      r.sof = s;
      r.eof = eo;
      r.cyc = cyc;
      return r;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         q.delete();
         sm = 2'd0; sy = 0; scbn = 0; scbx = 255; scrn = 0; scrx = 255;
         cnt = 0; exp_cv = 0; hold_v = 0;
      end else begin
         chk("count_valid", count_valid, exp_cv);
         if (exp_cv) chk("match_count", match_count, exp_cnt);
         if (count_valid && ncnt < 16) begin cnt_log[ncnt] = match_count; ncnt++; end
         exp_cv = 0;
         chk("in_ready", in_ready, !out_valid || out_ready);
         if (hold_v) chk("stall_stable", {out_pixel, out_sof, out_eof, out_match}, hold);
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               e = q.pop_front();
               chk("out_pixel", out_pixel, e.px);
               chk("out_sof", out_sof, e.sof);
               chk("out_eof", out_eof, e.eof);
               chk("out_match", out_match, e.m);
               if (nlog < 64) begin log_px[nlog] = out_pixel; log_lat[nlog] = cyc - e.cyc; nlog++; end
               cnt = e.sof ? int'(e.m) : (cnt == CMAX ? cnt : cnt + int'(e.m));
               if (e.eof) begin exp_cv = 1; exp_cnt = cnt; end
            end
         end
         hold_v = out_valid && !out_ready;
         hold = {out_pixel, out_sof, out_eof, out_match};
         if (in_valid && in_ready) begin
            if (in_sof) begin sm = mode; sy = y_min; scbn = cb_min; scbx = cb_max; scrn = cr_min; scrx = cr_max; end
            q.push_back(model(in_pixel, in_sof, in_eof));
         end
      end
   end

   task automatic send(input logic [PW-1:0] p, input logic s, input logic eo);
      int k = 0;
      in_pixel = p; in_sof = s; in_eof = eo; in_valid = 1;
      @(negedge clk);
      while (!in_ready && k < 100) begin k++; @(negedge clk); end
      if (k == 100) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 0; in_sof = 0; in_eof = 0;
   endtask

   task automatic frame5(input bit chg);
      send(12'hF00, 1, 0);
      if (chg) begin cr_min = 8'd0; cb_max = 8'd255; end
      send(12'h0F0, 0, 0);
      send(12'h00F, 0, 0);
      send(12'h888, 0, 0);
      send(12'hFF0, 0, 1);
   endtask

   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 60) begin @(negedge clk); k++; end
      if (k == 60) chk("drain_timeout", 0, 1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic wait_cv8(input logic [2:0] req, input string name);
      int k = 0;
      @(negedge clk);
      while (!count_valid8 && k < 20) begin @(negedge clk); k++; end
      chk({name, "_seen"}, count_valid8, 1);
      chk(name, match_count8, req);
   endtask

   initial begin
      int b, c0;
      logic [PW-1:0] f1 [5];
      logic [PW-1:0] f3 [5];
      f1 = '{12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000};
      f3 = '{12'h444, 12'h999, 12'h111, 12'h888, 12'hEEE};
      repeat (2) @(posedge clk);
      #1 reset_n = 1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", match_count, 0);
      chk("rst_pixel", out_pixel, 0);
      chk("rst_cv", count_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      // binary mask, back-to-back
      b = nlog; c0 = ncnt;
      frame5(0);
      drain();
      for (int i = 0; i < 5; i++) begin
         chk("f1_pixel", log_px[b+i], f1[i]);
         chk("f1_latency", log_lat[b+i], 4);
      end
      chk("f1_count", cnt_log[c0], 1);
      // masked colour
      mode = 2'b10; b = nlog;
      frame5(0);
      drain();
      chk("f2_red", log_px[b], 12'hF00);
      chk("f2_green", log_px[b+1], 12'h000);
      // grayscale
      mode = 2'b11; b = nlog;
      frame5(0);
      drain();
      for (int i = 0; i < 5; i++) chk("f3_gray", log_px[b+i], f3[i]);
      // back-pressure mid-stream
      mode = 2'b01; b = nlog; c0 = ncnt;
      fork
         frame5(0);
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 0;
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            repeat (5) @(posedge clk);
            #1 out_ready = 1;
         end
      join
      drain();
      chk("stall_n_out", nlog - b, 5);
      for (int i = 0; i < 5; i++) chk("stall_pixel", log_px[b+i], f1[i]);
      chk("stall_count", cnt_log[c0], 1);
      // config change mid-frame applies only from the next sof
      c0 = ncnt;
      frame5(1);
      drain();
      frame5(0);
      drain();
      chk("midchg_count", cnt_log[c0], 1);
      chk("newcfg_count", cnt_log[c0+1], 4);
      // 8-pixel and single-pixel frames
      c0 = ncnt;
      for (int i = 0; i < 8; i++) send(12'hF00, i == 0, i == 7);
      drain();
      send(12'hF00, 1, 1);
      drain();
      chk("eight_count", cnt_log[c0], 8);
      chk("single_count", cnt_log[c0+1], 1);
      // reset with 3 pixels in flight
      c0 = ncnt;
      send(12'hF00, 1, 0);
      send(12'h0F0, 0, 0);
      send(12'h00F, 0, 0);
      reset_n = 0;
      @(posedge clk); #1;
      reset_n = 1;
      @(negedge clk);
      chk("rst_mid_valid", out_valid, 0);
      repeat (6) @(negedge clk);
      chk("rst_no_cv", ncnt - c0, 0);
      @(posedge clk); #1;
      mode = 2'b01; y_min = 8'd200;
      b = nlog;
      send(12'h00F, 0, 1);
      drain();
      chk("rst_shadow_px", log_px[b], 12'h00F);
      chk("rst_eof_count", cnt_log[c0], 1);
      chk("queue_empty", q.size(), 0);
      // 8-bit colour, 3-bit counter saturation
      for (int i = 0; i < 9; i++) begin
         in_valid8 = 1; in_sof8 = (i == 0); in_eof8 = (i == 8);
         @(posedge clk); #1;
      end
      in_valid8 = 0; in_sof8 = 0; in_eof8 = 0;
      @(negedge clk);
      chk("px8_valid", out_valid8, 1);
      chk("px8", out_pixel8, 24'hFF0000);
      wait_cv8(3'd7, "sat_count");
      @(posedge clk); #1;
      in_valid8 = 1; in_sof8 = 1; in_eof8 = 1;
      @(posedge clk); #1;
      in_valid8 = 0; in_sof8 = 0; in_eof8 = 0;
      wait_cv8(3'd1, "single8_count");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
